seg_scan_rx: RTL and testbench

- Receive end of the multiplexed 7-segment display bus: observes the scanned segment, decimal-point and active-low digit-enable lines and rebuilds the six displayed digits.
- Decodes each digit's segment pattern back to BCD and presents a coherent snapshot once per full scan frame.
- Also presents binary minutes and seconds.
- Used as an on-chip display monitor and as the self-checking observer in clock-system benches.

---
 rtl/seg_scan_rx_pkg.sv | 50 +++++
 rtl/seg_pat_dec.sv | 35 +++
 rtl/seg_scan_rx.sv | 189 ++++++++++++++++++
 tb/tb_seg_scan_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_rx_pkg.sv
// Shared definitions for the multiplexed 7-segment display receiver:
// FSM state type, segment pattern constants, nibble codes and helpers
// for inspecting the active-low digit-enable bus.
package seg_scan_rx_pkg;

   localparam int NUM_DIG = 6;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // Segment patterns as driven on the bus, bit order {a,b,c,d,e,f,g}
   localparam logic [6:0] SEG_0     = 7'h7E;
   localparam logic [6:0] SEG_1     = 7'h30;
   localparam logic [6:0] SEG_2     = 7'h6D;
   localparam logic [6:0] SEG_3     = 7'h79;
   localparam logic [6:0] SEG_4     = 7'h33;
   localparam logic [6:0] SEG_5     = 7'h5B;
   localparam logic [6:0] SEG_6     = 7'h5F;
   localparam logic [6:0] SEG_7     = 7'h70;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h73;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [3:0] DIG_BLANK = 4'hF;
   localparam logic [3:0] DIG_BAD   = 4'hE;

   // Number of digits currently selected (enable bits driven low)
   function automatic logic [2:0] lowCount(input logic [5:0] enb);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < NUM_DIG; i++) begin
         if (!enb[i]) n = n + 3'd1;
      end
      return n;
   endfunction

   // Index of the lowest selected digit; meaningful when exactly one is low
   function automatic logic [2:0] lowIndex(input logic [5:0] enb);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = NUM_DIG - 1; i >= 0; i--) begin
         if (!enb[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/seg_pat_dec.sv
// Inverse of the display decoder: turns a lit-segment pattern back into
// a BCD nibble. A dark digit reads as DIG_BLANK; any pattern that is not
// a digit or blank reads as DIG_BAD and raises o_bad.
module seg_pat_dec
   import seg_scan_rx_pkg::*;
(
   input  logic [6:0] i_pat,
   output logic [3:0] o_code,
   output logic       o_bad
);

   // Table lookup from segment pattern to digit code
   always_comb begin
      o_code = DIG_BAD;
      o_bad  = 1'b0;
      case (i_pat)
         SEG_0:     o_code = 4'd0;
         SEG_1:     o_code = 4'd1;
         SEG_2:     o_code = 4'd2;
         SEG_3:     o_code = 4'd3;
         SEG_4:     o_code = 4'd4;
         SEG_5:     o_code = 4'd5;
         SEG_6:     o_code = 4'd6;
         SEG_7:     o_code = 4'd7;
         SEG_8:     o_code = 4'd8;
         SEG_9:     o_code = 4'd9;
         SEG_BLANK: o_code = DIG_BLANK;
         default: begin
            o_code = DIG_BAD;
            o_bad  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/seg_scan_rx.sv
// Receive end of the multiplexed 7-segment display bus. Waits for each
// scanned digit to sit still for SETTLE_CYC cycles, captures it once per
// dwell into a shadow frame, and publishes the whole frame (plus binary
// minutes/seconds) once all six digits have been seen.
// Optional scan-stall watchdog: define SEG_SCAN_TIMEOUT_EN.
module seg_scan_rx
   import seg_scan_rx_pkg::*;
#(
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  i_seg,
   input  logic        i_seg_dp,
   input  logic [5:0]  i_seg_enb,
   output logic [23:0] o_digits,
   output logic [5:0]  o_dp,
   output logic [5:0]  o_sec,
   output logic [5:0]  o_min,
   output logic        o_frame_vld,
   output logic        o_err,
   output logic        o_stall
);

   localparam logic [15:0] SETTLE_MAX = 16'(SETTLE_CYC);
   localparam logic [15:0] SETTLE_M1  = 16'(SETTLE_CYC - 1);

   logic [6:0]  r_segIn, r_segPrev;
   logic        r_dpIn, r_dpPrev;
   logic [5:0]  r_enbIn, r_enbPrev;
   logic [15:0] r_cnt;
   state_t      r_state;
   logic [23:0] r_shDig;
   logic [5:0]  r_shDp;
   logic [5:0]  r_mask;
   logic [23:0] r_digits;
   logic [5:0]  r_dpOut;
   logic [5:0]  r_sec, r_min;
   logic        r_frameVld;
   logic        r_err;

   logic        w_chg, w_enbChg;
   logic [2:0]  w_lowCnt, w_idx;
   logic        w_oneHot, w_multi;
   logic        w_capture;
   logic [3:0]  w_code;
   logic        w_patBad;
   logic [5:0]  w_idxBit;
   logic        w_maskFull;
   logic [3:0]  w_d0, w_d1, w_d2, w_d3;
   logic        w_bcdBad;
   logic [5:0]  w_sec, w_min;

   seg_pat_dec u_dec (
      .i_pat  (r_segIn),
      .o_code (w_code),
      .o_bad  (w_patBad)
   );

   assign w_chg      = {r_segIn, r_dpIn, r_enbIn} != {r_segPrev, r_dpPrev, r_enbPrev};
   assign w_enbChg   = r_enbIn != r_enbPrev;
   assign w_lowCnt   = lowCount(r_enbIn);
   assign w_idx      = lowIndex(r_enbIn);
   assign w_oneHot   = w_lowCnt == 3'd1;
   assign w_multi    = w_lowCnt >= 3'd2;
   assign w_capture  = (r_state == ST_SETTLE) && !w_chg && (r_cnt == SETTLE_M1);
   assign w_idxBit   = 6'b000001 << w_idx;
   assign w_maskFull = r_mask == 6'h3F;

   assign w_d0     = r_shDig[3:0];
   assign w_d1     = r_shDig[7:4];
   assign w_d2     = r_shDig[11:8];
   assign w_d3     = r_shDig[15:12];
   assign w_bcdBad = (w_d0 > 4'd9) || (w_d1 > 4'd9) || (w_d2 > 4'd9) || (w_d3 > 4'd9);
   assign w_sec    = 6'({3'b000, w_d1} * 7'd10 + {3'b000, w_d0});
   assign w_min    = 6'({3'b000, w_d3} * 7'd10 + {3'b000, w_d2});

   // Register the bus once, and keep the previous sample to detect changes
   always_ff @(posedge clk) begin
      if (rst) begin
         r_segIn   <= 7'h00;
         r_dpIn    <= 1'b0;
         r_enbIn   <= 6'h3F;
         r_segPrev <= 7'h00;
         r_dpPrev  <= 1'b0;
         r_enbPrev <= 6'h3F;
      end else begin
         r_segIn   <= i_seg;
         r_dpIn    <= i_seg_dp;
         r_enbIn   <= i_seg_enb;
         r_segPrev <= r_segIn;
         r_dpPrev  <= r_dpIn;
         r_enbPrev <= r_enbIn;
      end
   end

   // Count how long the registered bus has been stable, saturating
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= 16'd0;
      end else if (w_chg) begin
         r_cnt <= 16'd0;
      end else if (r_cnt != SETTLE_MAX) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   // Dwell tracking: any change restarts, one capture per stable dwell
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else if (w_chg) begin
         r_state <= w_oneHot ? ST_SETTLE : ST_IDLE;
      end else if (w_capture) begin
         r_state <= ST_HOLD;
      end
   end

   // Capture into the shadow frame, publish full frames, flag errors
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shDig    <= 24'h000000;
         r_shDp     <= 6'h00;
         r_mask     <= 6'h00;
         r_digits   <= 24'hFFFFFF;
         r_dpOut    <= 6'h00;
         r_sec      <= 6'd0;
         r_min      <= 6'd0;
         r_frameVld <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_frameVld <= 1'b0;
         r_err      <= (w_capture && w_patBad) || (w_enbChg && w_multi);
         if (w_capture) begin
            r_shDig[{w_idx, 2'b00} +: 4] <= w_code;
            r_shDp[w_idx]                <= r_dpIn;
         end
         if (w_maskFull) begin
            r_digits   <= r_shDig;
            r_dpOut    <= r_shDp;
            r_sec      <= w_bcdBad ? 6'd0 : w_sec;
            r_min      <= w_bcdBad ? 6'd0 : w_min;
            r_frameVld <= 1'b1;
            if (w_bcdBad) r_err <= 1'b1;
            r_mask     <= w_capture ? w_idxBit : 6'h00;
         end else if (w_capture) begin
            r_mask <= r_mask | w_idxBit;
         end
      end
   end

   assign o_digits    = r_digits;
   assign o_dp        = r_dpOut;
   assign o_sec       = r_sec;
   assign o_min       = r_min;
   assign o_frame_vld = r_frameVld;
   assign o_err       = r_err;

`ifdef SEG_SCAN_TIMEOUT_EN
   localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT_CYC - 1);

   logic [31:0] r_wdog;
   logic        r_stall;
   logic [31:0] w_wdogNext;

   assign w_wdogNext = (r_wdog == TIMEOUT_M1) ? r_wdog : r_wdog + 32'd1;

   // Watchdog: cycles since the last capture, stall raised at the limit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdog  <= 32'd0;
         r_stall <= 1'b0;
      end else if (w_capture) begin
         r_wdog  <= 32'd0;
         r_stall <= 1'b0;
      end else begin
         r_wdog <= w_wdogNext;
         if (w_wdogNext == TIMEOUT_M1) r_stall <= 1'b1;
      end
   end

   assign o_stall = r_stall;
`else
   // Watchdog compiled out; no legal timeout value can raise the flag
   assign o_stall = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_seg_scan_rx.sv
// Directed bench for seg_scan_rx: drives scanned digits on the display
// bus and compares the rebuilt frame against hand-computed values.
// Define SEG_SCAN_TIMEOUT_EN to also exercise the stall watchdog.
module tb_seg_scan_rx;

   localparam int SETTLE = 16;
   localparam int GAP    = 4;

   logic        clk;
   logic        rst;
   logic [6:0]  i_seg;
   logic        i_seg_dp;
   logic [5:0]  i_seg_enb;
   logic [23:0] o_digits;
   logic [5:0]  o_dp;
   logic [5:0]  o_sec;
   logic [5:0]  o_min;
   logic        o_frame_vld;
   logic        o_err;
   logic        o_stall;

   int total = 0;
   int bad   = 0;
   int frameCnt = 0;
   int errCnt   = 0;
   int f0, e0;

   // 12:34 -> d0=4, d1=3, d2=2, d3=1, d4/d5 blank
   logic [6:0] patA [6] = '{7'h33, 7'h79, 7'h6D, 7'h30, 7'h00, 7'h00};
   // 68:59:07 -> d0=7, d1=0, d2=9, d3=5, d4=8, d5=6
   logic [6:0] patB [6] = '{7'h70, 7'h7E, 7'h73, 7'h5B, 7'h7F, 7'h5F};

   seg_scan_rx #(
      .SETTLE_CYC  (SETTLE),
      .TIMEOUT_CYC (200)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_seg       (i_seg),
      .i_seg_dp    (i_seg_dp),
      .i_seg_enb   (i_seg_enb),
      .o_digits    (o_digits),
      .o_dp        (o_dp),
      .o_sec       (o_sec),
      .o_min       (o_min),
      .o_frame_vld (o_frame_vld),
      .o_err       (o_err),
      .o_stall     (o_stall)
   );

   // 10 time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count frame and error pulses as they are seen on each clock edge
   always @(posedge clk) begin
      if (o_frame_vld === 1'b1) frameCnt++;
      if (o_err === 1'b1) errCnt++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present one digit for dwell cycles, then an all-high blank gap
   task automatic applyStimulus(input int k, input logic [6:0] pat, input logic dp, input int dwell);
      i_seg_enb = ~(6'b000001 << k);
      i_seg     = pat;
      i_seg_dp  = dp;
      repeat (dwell) @(negedge clk);
      i_seg_enb = 6'h3F;
      i_seg     = 7'h00;
      i_seg_dp  = 1'b0;
      repeat (GAP) @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      i_seg     = 7'h00;
      i_seg_dp  = 1'b0;
      i_seg_enb = 6'h3F;
      repeat (3) @(negedge clk);

      $display("[TB] reset values");
      checkOutput("rst_digits", 32'(o_digits), 32'hFFFFFF);
      checkOutput("rst_dp", 32'(o_dp), 32'h0);
      checkOutput("rst_sec", 32'(o_sec), 32'd0);
      checkOutput("rst_min", 32'(o_min), 32'd0);
      checkOutput("rst_vld", 32'(o_frame_vld), 32'd0);
      checkOutput("rst_err", 32'(o_err), 32'd0);
      checkOutput("rst_stall", 32'(o_stall), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] frame 12:34");
      f0 = frameCnt; e0 = errCnt;
      for (int k = 0; k < 6; k++) applyStimulus(k, patA[k], 1'b0, 40);
      checkOutput("f1_count", 32'(frameCnt - f0), 32'd1);
      checkOutput("f1_err", 32'(errCnt - e0), 32'd0);
      checkOutput("f1_digits", 32'(o_digits), 32'hFF1234);
      checkOutput("f1_min", 32'(o_min), 32'd12);
      checkOutput("f1_sec", 32'(o_sec), 32'd34);
      checkOutput("f1_dp", 32'(o_dp), 32'h00);

      $display("[TB] frame 68:59:07 with dp on digit 2");
      f0 = frameCnt; e0 = errCnt;
      for (int k = 0; k < 6; k++) applyStimulus(k, patB[k], (k == 2), 40);
      checkOutput("f2_count", 32'(frameCnt - f0), 32'd1);
      checkOutput("f2_digits", 32'(o_digits), 32'h685907);
      checkOutput("f2_min", 32'(o_min), 32'd59);
      checkOutput("f2_sec", 32'(o_sec), 32'd7);
      checkOutput("f2_dp", 32'(o_dp), 32'h04);

      $display("[TB] short dwell on digit 2");
      f0 = frameCnt;
      applyStimulus(0, patA[0], 1'b0, 40);
      applyStimulus(1, patA[1], 1'b0, 40);
      applyStimulus(2, patA[2], 1'b0, SETTLE - 1);
      applyStimulus(3, patA[3], 1'b0, 40);
      applyStimulus(4, patA[4], 1'b0, 40);
      applyStimulus(5, patA[5], 1'b0, 40);
      checkOutput("short_nofrm", 32'(frameCnt - f0), 32'd0);
      checkOutput("short_hold", 32'(o_digits), 32'h685907);
      applyStimulus(2, patA[2], 1'b0, SETTLE + 1);
      checkOutput("min_dwell_frm", 32'(frameCnt - f0), 32'd1);
      checkOutput("min_dwell_dig", 32'(o_digits), 32'hFF1234);

      $display("[TB] bad pattern on digit 0");
      f0 = frameCnt; e0 = errCnt;
      applyStimulus(0, 7'h7A, 1'b0, 40);
      checkOutput("badpat_err1", 32'(errCnt - e0), 32'd1);
      for (int k = 1; k < 6; k++) applyStimulus(k, patA[k], 1'b0, 40);
      checkOutput("badpat_err2", 32'(errCnt - e0), 32'd2);
      checkOutput("badpat_frm", 32'(frameCnt - f0), 32'd1);
      checkOutput("badpat_dig", 32'(o_digits), 32'hFF123E);
      checkOutput("badpat_sec", 32'(o_sec), 32'd0);

      $display("[TB] two enables low");
      f0 = frameCnt; e0 = errCnt;
      i_seg_enb = 6'h3C;
      i_seg     = 7'h5B;
      repeat (40) @(negedge clk);
      i_seg_enb = 6'h3F;
      i_seg     = 7'h00;
      repeat (GAP) @(negedge clk);
      checkOutput("multi_err", 32'(errCnt - e0), 32'd1);
      checkOutput("multi_nofrm", 32'(frameCnt - f0), 32'd0);
      for (int k = 0; k < 6; k++) applyStimulus(k, patA[k], (k == 2), 40);
      checkOutput("multi_recov_frm", 32'(frameCnt - f0), 32'd1);
      checkOutput("multi_recov_err", 32'(errCnt - e0), 32'd1);
      checkOutput("multi_recov_dig", 32'(o_digits), 32'hFF1234);
      checkOutput("multi_recov_dp", 32'(o_dp), 32'h04);

      $display("[TB] reset mid-frame");
      for (int k = 0; k < 3; k++) applyStimulus(k, patB[k], 1'b0, 40);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("midrst_digits", 32'(o_digits), 32'hFFFFFF);
      checkOutput("midrst_dp", 32'(o_dp), 32'h00);
      checkOutput("midrst_sec", 32'(o_sec), 32'd0);
      checkOutput("midrst_min", 32'(o_min), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      f0 = frameCnt;
      for (int k = 3; k < 6; k++) applyStimulus(k, patA[k], 1'b0, 40);
      checkOutput("midrst_partial", 32'(frameCnt - f0), 32'd0);
      for (int k = 0; k < 3; k++) applyStimulus(k, patA[k], 1'b0, 40);
      checkOutput("midrst_frm", 32'(frameCnt - f0), 32'd1);
      checkOutput("midrst_dig2", 32'(o_digits), 32'hFF1234);
      checkOutput("midrst_min2", 32'(o_min), 32'd12);
      checkOutput("midrst_sec2", 32'(o_sec), 32'd34);

`ifdef SEG_SCAN_TIMEOUT_EN
      $display("[TB] scan stall watchdog");
      applyStimulus(0, patA[0], 1'b0, 20);
      repeat (150) @(negedge clk);
      checkOutput("stall_early", 32'(o_stall), 32'd0);
      repeat (100) @(negedge clk);
      checkOutput("stall_set", 32'(o_stall), 32'd1);
      applyStimulus(1, patA[1], 1'b0, 20);
      checkOutput("stall_clear", 32'(o_stall), 32'd0);
`else
      checkOutput("stall_off", 32'(o_stall), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
